// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: 8XYN opcode encodings and ALU datapath widths.
// Also used by the instruction decoder.
package chip8_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_LD   = 4'h0;
   localparam logic [OP_W-1:0] OP_OR   = 4'h1;
   localparam logic [OP_W-1:0] OP_AND  = 4'h2;
   localparam logic [OP_W-1:0] OP_XOR  = 4'h3;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h5;
   localparam logic [OP_W-1:0] OP_SHR  = 4'h6;
   localparam logic [OP_W-1:0] OP_SUBN = 4'h7;
   localparam logic [OP_W-1:0] OP_SHL  = 4'hE;

   // ALU result bundle as seen by the register-file write-back stage
   typedef struct packed {
      logic [DATA_W-1:0] res;
      logic              flag;
      logic              err;
   } alu_result_t;

endpackage

// File: rtl/chip8_alu_core.sv
// Combinational 8XYN datapath: result, VF flag and unsupported-opcode error.
module chip8_alu_core
   import chip8_pkg::*;
(
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   input  logic [OP_W-1:0]   opcode,
   output alu_result_t       result_c
);

   logic [DATA_W:0] sum_c;
   logic [DATA_W:0] diff_xy_c;
   logic [DATA_W:0] diff_yx_c;

   // Ninth bit of each subtraction is the borrow; VF is its inverse
   assign sum_c     = {1'b0, op1} + {1'b0, op2};
   assign diff_xy_c = {1'b0, op1} - {1'b0, op2};
   assign diff_yx_c = {1'b0, op2} - {1'b0, op1};

   always_comb begin
      result_c      = '0;
      result_c.err  = 1'b0;
      unique case (opcode)
         OP_LD:   result_c.res = op2;
         OP_OR:   result_c.res = op1 | op2;
         OP_AND:  result_c.res = op1 & op2;
         OP_XOR:  result_c.res = op1 ^ op2;
         OP_ADD: begin
            result_c.res  = sum_c[DATA_W-1:0];
            result_c.flag = sum_c[DATA_W];
         end
         OP_SUB: begin
            result_c.res  = diff_xy_c[DATA_W-1:0];
            result_c.flag = ~diff_xy_c[DATA_W];
         end
         OP_SHR: begin
            result_c.res  = {1'b0, op1[DATA_W-1:1]};
            result_c.flag = op1[0];
         end
         OP_SUBN: begin
            result_c.res  = diff_yx_c[DATA_W-1:0];
            result_c.flag = ~diff_yx_c[DATA_W];
         end
         OP_SHL: begin
            result_c.res  = {op1[DATA_W-2:0], 1'b0};
            result_c.flag = op1[DATA_W-1];
         end
         default: result_c.err = 1'b1;
      endcase
   end

endmodule

// File: rtl/chip8_alu.sv
// CHIP-8 ALU top: registers the combinational datapath result once per clock.
module chip8_alu
   import chip8_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   input  logic [OP_W-1:0]   opcode,
   output logic [DATA_W-1:0] out,
   output logic              carry,
   output logic              ALU_ERR
);

   alu_result_t result_c;

   chip8_alu_core u_core (
      .op1      (op1),
      .op2      (op2),
      .opcode   (opcode),
      .result_c (result_c)
   );

   // No enable: every edge loads a fresh result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out     <= '0;
         carry   <= 1'b0;
         ALU_ERR <= 1'b0;
      end else begin
         out     <= result_c.res;
         carry   <= result_c.flag;
         ALU_ERR <= result_c.err;
      end
   end

endmodule

// File: tb/tb_chip8_alu.sv
// Scoreboard bench for chip8_alu: expected results queued at drive, popped one edge later.
module tb_chip8_alu;

   typedef struct packed {
      logic [7:0] o;
      logic       c;
      logic       e;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] op1;
   logic [7:0] op2;
   logic [3:0] opcode;
   logic [7:0] out;
   logic       carry;
   logic       ALU_ERR;

   int   n_checks;
   int   n_fail;
   exp_t sb_q[$];

   chip8_alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .op1     (op1),
      .op2     (op2),
      .opcode  (opcode),
      .out     (out),
      .carry   (carry),
      .ALU_ERR (ALU_ERR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour written from the instruction definitions in integer arithmetic
   function automatic exp_t model(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
      exp_t r;
      int   ia, ib, s;
      ia = int'(a);
      ib = int'(b);
      r  = '0;
      case (opc)
         4'h0: r.o = b;
         4'h1: r.o = a | b;
         4'h2: r.o = a & b;
         4'h3: r.o = a ^ b;
         4'h4: begin s = ia + ib; r.o = 8'(s % 256); r.c = (s > 255); end
         4'h5: begin r.o = 8'((ia + 256 - ib) % 256); r.c = (ia >= ib); end
         4'h6: begin r.o = 8'(ia / 2); r.c = (ia % 2) == 1; end
         4'h7: begin r.o = 8'((ib + 256 - ia) % 256); r.c = (ib >= ia); end
         4'hE: begin r.o = 8'((ia * 2) % 256); r.c = (ia >= 128); end
         default: r.e = 1'b1;
      endcase
      return r;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_out"}, 16'(out), 16'h0);
      check({tag, "_carry"}, 16'(carry), 16'h0);
      check({tag, "_err"}, 16'(ALU_ERR), 16'h0);
   endtask

   // Drive at the falling edge, compare #1 after the rising edge that samples it
   task automatic do_op(input string tag, input logic [3:0] opc, input logic [7:0] a,
                        input logic [7:0] b);
      exp_t e;
      @(negedge clk);
      opcode = opc;
      op1    = a;
      op2    = b;
      sb_q.push_back(model(opc, a, b));
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_underflow"}, 16'(sb_q.size()), 16'h1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_out"}, 16'(out), 16'(e.o));
         check({tag, "_carry"}, 16'(carry), 16'(e.c));
         check({tag, "_err"}, 16'(ALU_ERR), 16'(e.e));
      end
   endtask

   // Assert reset between edges and confirm the outputs clear without a clock edge
   task automatic reset_pulse(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero(tag);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      op1      = 8'h00;
      op2      = 8'h00;
      opcode   = 4'h4;
      #1;
      check_zero("reset_early");
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_clocked");
      @(negedge clk);
      rst_n = 1'b1;

      do_op("add_0_0",   4'h4, 8'h00, 8'h00);
      do_op("add_ff_0",  4'h4, 8'hFF, 8'h00);
      do_op("add_ff_1",  4'h4, 8'hFF, 8'h01);
      do_op("sub_ff_1",  4'h5, 8'hFF, 8'h01);
      do_op("subn_ff_1", 4'h7, 8'hFF, 8'h01);
      do_op("sub_eq",    4'h5, 8'h10, 8'h10);
      do_op("subn_eq",   4'h7, 8'h10, 8'h10);
      do_op("shr_ff",    4'h6, 8'hFF, 8'h55);
      do_op("shl_ff",    4'hE, 8'hFF, 8'h55);
      do_op("shr_02",    4'h6, 8'h02, 8'hFF);
      do_op("ld",        4'h0, 8'hFF, 8'h01);
      do_op("or",        4'h1, 8'hFF, 8'h01);
      do_op("and",       4'h2, 8'hFF, 8'h01);
      do_op("xor",       4'h3, 8'hFF, 8'h01);
      do_op("err_8",     4'h8, 8'hFF, 8'h01);
      do_op("err_f",     4'hF, 8'hFF, 8'h01);
      reset_pulse("rst_after_err");
      do_op("shl_80",    4'hE, 8'h80, 8'h00);
      reset_pulse("rst_after_shl");
      do_op("add_post",  4'h4, 8'h7F, 8'h01);

      for (int i = 0; i < 48; i++) begin
         do_op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      check("sb_empty", 16'(sb_q.size()), 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
